tdm_demux4: RTL and testbench

//   Receive end of the 4:1 time-division link driven by the Mux4_1 datapath.

---
 rtl/tdm_pkg.sv | 17 +
 rtl/demux_slot_reg.sv | 20 ++
 rtl/tdm_demux4.sv | 107 ++++++++++
 tb/tb_tdm_demux4.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared constants and state encoding for the TDM receive path.
package tdm_pkg;

    localparam int SLOT_W = 2;
    localparam int NUM_CH = 4;

    localparam logic [SLOT_W-1:0] SLOT0 = 2'd0;
    localparam logic [SLOT_W-1:0] SLOT1 = 2'd1;
    localparam logic [SLOT_W-1:0] SLOT2 = 2'd2;
    localparam logic [SLOT_W-1:0] SLOT3 = 2'd3;

    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

endpackage

// File: rtl/demux_slot_reg.sv
// One staging register of the demux: async active-low clear, write enable.
module demux_slot_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Capture d when enabled, hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= '0;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/tdm_demux4.sv
// Receive side of the 4:1 TDM link: steers slot words into staging
// registers and publishes a complete frame on all channels at once.
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NUM_CH = tdm_pkg::NUM_CH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [WIDTH-1:0]        din,
    input  logic                    din_valid,
    input  logic                    frame_sync,
    output logic [NUM_CH*WIDTH-1:0] ch_data,
    output logic                    frame_valid,
    output logic                    sync_err,
    output logic [SLOT_W-1:0]       slot
);

    state_t              state_q, state_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic                wr_req;
    logic [SLOT_W-1:0]   wr_idx;
    logic [3:0]          slot_en;
    logic                err_d;
    logic [WIDTH-1:0]    staging [3];

    // Next-state, slot pointer and write request from the incoming beat.
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        wr_req  = 1'b0;
        wr_idx  = SLOT0;
        err_d   = 1'b0;
        if (din_valid) begin
            unique case (state_q)
                ST_HUNT: begin
                    if (frame_sync) begin
                        wr_req  = 1'b1;
                        wr_idx  = SLOT0;
                        slot_d  = SLOT1;
                        state_d = ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    wr_req = 1'b1;
                    if (frame_sync && slot_q != SLOT0) begin
                        // Misplaced sync restarts the frame; slot 3 is never
                        // reached on this beat, so no publish occurs.
                        err_d  = 1'b1;
                        wr_idx = SLOT0;
                        slot_d = SLOT1;
                    end else begin
                        wr_idx = slot_q;
                        slot_d = slot_q + 2'd1;
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end
    end

    // 2->4 one-hot slot decoder; bit 3 doubles as the publish strobe.
    always_comb begin
        slot_en = '0;
        if (wr_req)
            slot_en[wr_idx] = 1'b1;
    end

    // Framing state and slot pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_HUNT;
            slot_q  <= SLOT0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_stage
        demux_slot_reg #(.WIDTH(WIDTH)) u_stage (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (slot_en[i]),
            .d     (din),
            .q     (staging[i])
        );
    end

    // Publish register and status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_data     <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            frame_valid <= slot_en[SLOT3];
            sync_err    <= err_d;
            if (slot_en[SLOT3])
                ch_data <= {din, staging[2], staging[1], staging[0]};
        end
    end

    assign slot = slot_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Randomised and directed scoreboard bench for tdm_demux4.
module tb_tdm_demux4;

    localparam int W = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [W-1:0]  din = '0;
    logic          din_valid = 1'b0;
    logic          frame_sync = 1'b0;
    logic [4*W-1:0] ch_data;
    logic          frame_valid;
    logic          sync_err;
    logic [1:0]    slot;

    tdm_demux4 #(.WIDTH(W), .NUM_CH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .din_valid   (din_valid),
        .frame_sync  (frame_sync),
        .ch_data     (ch_data),
        .frame_valid (frame_valid),
        .sync_err    (sync_err),
        .slot        (slot)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: framing lock flag, next slot index, words of the frame.
    bit          m_locked = 0;
    int          m_slot   = 0;
    logic [W-1:0] m_word [4];
    logic [31:0] exp_hold = '0;

    typedef struct { logic [31:0] data; int unsigned when; } pub_t;
    pub_t        pub_q [$];
    int unsigned err_q [$];

    logic [1:0]  exp_slot;
    always @(posedge clk or negedge rst_n)
        if (!rst_n) exp_slot <= 2'd0;
        else        exp_slot <= 2'(m_slot);

    task automatic model_step(input logic v, input logic s, input logic [W-1:0] d);
        pub_t p;
        if (!v) return;
        if (!m_locked) begin
            if (s) begin
                m_word[0] = d;
                m_slot    = 1;
                m_locked  = 1;
            end
        end else if (s && m_slot != 0) begin
            err_q.push_back(cyc + 1);
            m_word[0] = d;
            m_slot    = 1;
        end else begin
            m_word[m_slot] = d;
            if (m_slot == 3) begin
                p.data = {m_word[3], m_word[2], m_word[1], m_word[0]};
                p.when = cyc + 1;
                pub_q.push_back(p);
            end
            m_slot = (m_slot + 1) % 4;
        end
    endtask

    task automatic beat(input logic v, input logic s, input logic [W-1:0] d);
        @(posedge clk);
        #1;
        din_valid  = v;
        frame_sync = s;
        din        = d;
        model_step(v, s, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) beat(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
    endtask

    task automatic frame(input logic [31:0] f, input int gap);
        for (int i = 0; i < 4; i++) begin
            beat(1'b1, i == 0, f[i*8 +: 8]);
            if (gap > 0) idle(gap);
        end
    endtask

    // Monitor: pops expected publishes/errors when the DUT presents them.
    always @(negedge clk) begin
        pub_t p;
        if (pub_q.size() > 0 && pub_q[0].when < cyc) begin
            p = pub_q.pop_front();
            chk("missed_frame_valid", 32'(p.when), 32'(cyc));
        end
        if (err_q.size() > 0 && err_q[0] < cyc) begin
            chk("missed_sync_err", err_q.pop_front(), cyc);
        end
        if (frame_valid) begin
            if (pub_q.size() == 0) begin
                chk("unexpected_frame_valid", 32'(frame_valid), 32'd0);
            end else begin
                p = pub_q.pop_front();
                chk("publish_cycle", cyc, p.when);
                chk("publish_data", ch_data, p.data);
                exp_hold = p.data;
            end
        end
        if (sync_err) begin
            if (err_q.size() == 0)
                chk("unexpected_sync_err", 32'(sync_err), 32'd0);
            else
                chk("sync_err_cycle", cyc, err_q.pop_front());
        end
        chk("ch_data_hold", ch_data, exp_hold);
        chk("slot", 32'(slot), 32'(exp_slot));
    end

    task automatic model_reset();
        m_locked = 0;
        m_slot   = 0;
        exp_hold = '0;
        pub_q.delete();
        err_q.delete();
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("reset_ch_data", ch_data, 32'h0);
        chk("reset_frame_valid", 32'(frame_valid), 32'd0);

        // Basic frame.
        frame(32'h44332211, 0);
        idle(2);
        // Words before any sync are dropped (after a fresh reset).
        @(posedge clk); #1 rst_n = 1'b0; model_reset();
        @(posedge clk); #1 rst_n = 1'b1;
        beat(1'b1, 1'b0, 8'hAA);
        beat(1'b1, 1'b0, 8'hBB);
        frame(32'h44332211, 0);
        idle(2);
        // Gaps of 0,3,1 between beats.
        beat(1'b1, 1'b1, 8'h11);
        beat(1'b1, 1'b0, 8'h22); idle(3);
        beat(1'b1, 1'b0, 8'h33); idle(1);
        beat(1'b1, 1'b0, 8'h44);
        idle(4);
        // Partial frame interrupted by a sync.
        beat(1'b1, 1'b1, 8'h01);
        beat(1'b1, 1'b0, 8'h02);
        frame(32'h40302010, 0);
        idle(2);
        // Back-to-back frames.
        frame(32'hDDCCBBAA, 0);
        frame(32'h87654321, 0);
        idle(2);
        // Reset after slot 2 of a frame.
        beat(1'b1, 1'b1, 8'hE0);
        beat(1'b1, 1'b0, 8'hE1);
        beat(1'b1, 1'b0, 8'hE2);
        @(posedge clk); #1 din_valid = 1'b0;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst_ch_data", ch_data, 32'h0);
        chk("async_rst_frame_valid", 32'(frame_valid), 32'd0);
        chk("async_rst_sync_err", 32'(sync_err), 32'd0);
        chk("async_rst_slot", 32'(slot), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        beat(1'b1, 1'b0, 8'h55);
        beat(1'b1, 1'b0, 8'h66);
        frame(32'h0C0B0A09, 1);
        idle(2);

        // Randomised traffic.
        for (int i = 0; i < 600; i++)
            beat($urandom_range(0, 3) != 0, $urandom_range(0, 6) == 0, 8'($urandom));
        idle(4);

        chk("pending_publishes", pub_q.size(), 0);
        chk("pending_sync_errs", err_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
